// File: rtl/reorder_buffer.sv
// Tomasulo reorder buffer: allocates tags in program order, captures CDB results, retires in order.
// Optional flush input is built when ROB_FLUSH_EN is defined.
module reorder_buffer #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 32,
  parameter  int REG_W  = 5,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rob_load,
  input  logic [REG_W-1:0]        alloc_rd,
  output logic [TAG_W-1:0]        rd_rob_tag,
  output logic                    rob_full,
  output logic                    rob_empty,
  input  logic [DEPTH-1:0]        cdb_enable,
  input  logic [DEPTH*DATA_W-1:0] cdb_data,
  output logic [DEPTH-1:0]        robs_calculated,
  input  logic [TAG_W-1:0]        rd_tag_a,
  input  logic [TAG_W-1:0]        rd_tag_b,
  output logic [DATA_W-1:0]       rd_data_a,
  output logic [DATA_W-1:0]       rd_data_b,
  output logic                    commit_valid,
  output logic [REG_W-1:0]        commit_rd,
  output logic [TAG_W-1:0]        commit_tag,
`ifdef ROB_FLUSH_EN
  input  logic                    flush,
`endif
  output logic [DATA_W-1:0]       commit_data
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] ONE_TAG  = TAG_W'(1);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  ready_q;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [TAG_W:0]    count_q;

  logic clear;
  logic do_alloc;
  logic do_commit;

`ifdef ROB_FLUSH_EN
  assign clear = rst | flush;
`else
  assign clear = rst;
`endif

  // Allocate handshake: rob_load is the valid, !rob_full the ready; an entry is
  // taken only when both are high at the edge, using the registered count, so a
  // same-cycle commit never makes room for an allocate presented while full.
  assign rob_full   = (count_q == FULL_CNT);
  assign rob_empty  = (count_q == '0);
  assign rd_rob_tag = tail_q;
  assign do_alloc   = rob_load && !rob_full && !clear;

  // Head retires as soon as its result is in; suppressed while state is being cleared.
  assign do_commit    = valid_q[head_q] && ready_q[head_q] && !clear;
  assign commit_valid = do_commit;
  assign commit_tag   = head_q;
  assign commit_rd    = do_commit ? rd_q[head_q]   : '0;
  assign commit_data  = do_commit ? data_q[head_q] : '0;

  assign robs_calculated = valid_q & ready_q;
  assign rd_data_a       = data_q[rd_tag_a];
  assign rd_data_b       = data_q[rd_tag_b];

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_enable[i] && valid_q[i]) begin
          ready_q[i] <= 1'b1;
        end
      end
      if (do_commit) begin
        valid_q[head_q] <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + ONE_TAG;
      end
      // Placed last so an allocate overrides a same-tag CDB capture.
      if (do_alloc) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + ONE_TAG;
      end
      case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      rd_q[tail_q] <= alloc_rd;
    end
  end

  // Result storage is never cleared; only pending writes during a clear are dropped.
  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_enable[i] && valid_q[i]) begin
          data_q[i] <= cdb_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= FULL_CNT);
  a_count_valid : assert property (@(posedge clk) disable iff (rst)
                                   $countones(valid_q) == int'(count_q));
  a_empty_quiet : assert property (@(posedge clk) disable iff (rst) rob_empty |-> !commit_valid);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for in-order retirement, hand sequences for
// mid-operation reset, full/wrap, broadcast-all and (with ROB_FLUSH_EN) flush.
module tb_reorder_buffer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int TAG_W  = 3;

  logic                    clk;
  logic                    rst;
  logic                    rob_load;
  logic [REG_W-1:0]        alloc_rd;
  logic [TAG_W-1:0]        rd_rob_tag;
  logic                    rob_full;
  logic                    rob_empty;
  logic [DEPTH-1:0]        cdb_enable;
  logic [DEPTH*DATA_W-1:0] cdb_data;
  logic [DEPTH-1:0]        robs_calculated;
  logic [TAG_W-1:0]        rd_tag_a;
  logic [TAG_W-1:0]        rd_tag_b;
  logic [DATA_W-1:0]       rd_data_a;
  logic [DATA_W-1:0]       rd_data_b;
  logic                    commit_valid;
  logic [REG_W-1:0]        commit_rd;
  logic [TAG_W-1:0]        commit_tag;
  logic [DATA_W-1:0]       commit_data;
`ifdef ROB_FLUSH_EN
  logic                    flush;
`endif

  int total = 0;
  int bad   = 0;

  reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk),
    .rst(rst),
    .rob_load(rob_load),
    .alloc_rd(alloc_rd),
    .rd_rob_tag(rd_rob_tag),
    .rob_full(rob_full),
    .rob_empty(rob_empty),
    .cdb_enable(cdb_enable),
    .cdb_data(cdb_data),
    .robs_calculated(robs_calculated),
    .rd_tag_a(rd_tag_a),
    .rd_tag_b(rd_tag_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .commit_valid(commit_valid),
    .commit_rd(commit_rd),
    .commit_tag(commit_tag),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .commit_data(commit_data)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              load;
    logic [REG_W-1:0]  rd;
    logic [DEPTH-1:0]  cdb_en;
    logic [DATA_W-1:0] cdb_val;
    logic [TAG_W-1:0]  e_tag;
    logic              e_full;
    logic              e_empty;
    logic [DEPTH-1:0]  e_calc;
    logic              e_cv;
    logic [REG_W-1:0]  e_crd;
    logic [TAG_W-1:0]  e_ctag;
    logic [DATA_W-1:0] e_cdata;
  } vec_t;

  vec_t vecs[9];

  // Scoreboard-style compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    rob_load   = 1'b0;
    alloc_rd   = '0;
    cdb_enable = '0;
    cdb_data   = '0;
    rd_tag_a   = '0;
    rd_tag_b   = '0;
`ifdef ROB_FLUSH_EN
    flush      = 1'b0;
`endif
  endtask

  task automatic set_cdb(input logic [DEPTH-1:0] en, input logic [DATA_W-1:0] base,
                         input bit distinct);
    cdb_enable = en;
    for (int i = 0; i < DEPTH; i++) begin
      cdb_data[i*DATA_W +: DATA_W] = distinct ? base + DATA_W'(i) : base;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle_inputs();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle_state(input string tag_name, input logic [TAG_W-1:0] exp_tag);
    chk({tag_name, "_empty"}, rob_empty, 1);
    chk({tag_name, "_full"}, rob_full, 0);
    chk({tag_name, "_tag"}, rd_rob_tag, exp_tag);
    chk({tag_name, "_calc"}, robs_calculated, 8'h00);
    chk({tag_name, "_cv"}, commit_valid, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd1, 8'h00, 32'd0,  3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 3'd0, 32'd0};
    vecs[1] = '{1'b1, 5'd2, 8'h00, 32'd0,  3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 3'd0, 32'd0};
    vecs[2] = '{1'b1, 5'd3, 8'h00, 32'd0,  3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 3'd0, 32'd0};
    vecs[3] = '{1'b0, 5'd0, 8'h02, 32'd11, 3'd3, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 3'd0, 32'd0};
    vecs[4] = '{1'b0, 5'd0, 8'h01, 32'd5,  3'd3, 1'b0, 1'b0, 8'h02, 1'b0, 5'd0, 3'd0, 32'd0};
    vecs[5] = '{1'b0, 5'd0, 8'h04, 32'd13, 3'd3, 1'b0, 1'b0, 8'h03, 1'b1, 5'd1, 3'd0, 32'd5};
    vecs[6] = '{1'b0, 5'd0, 8'h00, 32'd0,  3'd3, 1'b0, 1'b0, 8'h06, 1'b1, 5'd2, 3'd1, 32'd11};
    vecs[7] = '{1'b0, 5'd0, 8'h00, 32'd0,  3'd3, 1'b0, 1'b0, 8'h04, 1'b1, 5'd3, 3'd2, 32'd13};
    vecs[8] = '{1'b0, 5'd0, 8'h00, 32'd0,  3'd3, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 3'd3, 32'd0};

    // Reset held for five cycles
    do_reset(5);
    sample();
    chk_idle_state("reset", 3'd0);
    chk("reset_crd", commit_rd, 0);
    chk("reset_ctag", commit_tag, 0);
    chk("reset_cdata", commit_data, 0);
    tick();

    // Allocation, out-of-order completion, in-order retirement
    foreach (vecs[v]) begin
      idle_inputs();
      rob_load = vecs[v].load;
      alloc_rd = vecs[v].rd;
      set_cdb(vecs[v].cdb_en, vecs[v].cdb_val, 1'b0);
      sample();
      chk($sformatf("v%0d_tag", v), rd_rob_tag, vecs[v].e_tag);
      chk($sformatf("v%0d_full", v), rob_full, vecs[v].e_full);
      chk($sformatf("v%0d_empty", v), rob_empty, vecs[v].e_empty);
      chk($sformatf("v%0d_calc", v), robs_calculated, vecs[v].e_calc);
      chk($sformatf("v%0d_cv", v), commit_valid, vecs[v].e_cv);
      chk($sformatf("v%0d_crd", v), commit_rd, vecs[v].e_crd);
      chk($sformatf("v%0d_ctag", v), commit_tag, vecs[v].e_ctag);
      chk($sformatf("v%0d_cdata", v), commit_data, vecs[v].e_cdata);
      tick();
    end

    // Operand read ports
    idle_inputs();
    rd_tag_a = 3'd1;
    rd_tag_b = 3'd2;
    sample();
    chk("rd_a_tag1", rd_data_a, 32'd11);
    chk("rd_b_tag2", rd_data_b, 32'd13);
    rd_tag_a = 3'd0;
    #1;
    chk("rd_a_tag0", rd_data_a, 32'd5);
    tick();

    // Reset while the head is ready: no commit pulse, everything discarded
    idle_inputs();
    rob_load = 1'b1;
    alloc_rd = 5'd7;
    tick();
    alloc_rd = 5'd8;
    set_cdb(8'h08, 32'd77, 1'b0);
    tick();
    rst      = 1'b1;
    alloc_rd = 5'd9;
    set_cdb(8'h10, 32'd55, 1'b0);
    sample();
    chk("midrst_cv", commit_valid, 0);
    chk("midrst_cdata", commit_data, 0);
    tick();
    rst = 1'b0;
    idle_inputs();
    sample();
    chk_idle_state("midrst_after", 3'd0);
    chk("midrst_ctag", commit_tag, 0);
    tick();

    // Fill to DEPTH, drop while full, wrap the tail
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      rob_load = 1'b1;
      alloc_rd = REG_W'(10 + i);
      sample();
      chk($sformatf("fill%0d_tag", i), rd_rob_tag, i);
      chk($sformatf("fill%0d_full", i), rob_full, 0);
      tick();
    end
    idle_inputs();
    rob_load = 1'b1;
    alloc_rd = 5'd30;
    sample();
    chk("full_flag", rob_full, 1);
    chk("full_tag", rd_rob_tag, 0);
    chk("full_empty", rob_empty, 0);
    tick();
    set_cdb(8'h01, 32'd200, 1'b0);
    sample();
    chk("drop9_full", rob_full, 1);
    chk("drop9_tag", rd_rob_tag, 0);
    chk("drop9_cv", commit_valid, 0);
    tick();
    set_cdb(8'h00, 32'd0, 1'b0);
    sample();
    chk("cfull_cv", commit_valid, 1);
    chk("cfull_crd", commit_rd, 10);
    chk("cfull_cdata", commit_data, 200);
    chk("cfull_full", rob_full, 1);
    tick();
    sample();
    chk("wrap_full", rob_full, 0);
    chk("wrap_tag", rd_rob_tag, 0);
    chk("wrap_cv", commit_valid, 0);
    tick();
    idle_inputs();
    sample();
    chk("refill_full", rob_full, 1);
    chk("refill_tag", rd_rob_tag, 1);
    chk("refill_calc", robs_calculated, 8'h00);
    tick();

    // Broadcast all eight in one cycle, then eight back-to-back commits
    set_cdb(8'hFF, 32'd100, 1'b1);
    sample();
    chk("bcast_calc_pre", robs_calculated, 8'h00);
    tick();
    idle_inputs();
    for (int k = 0; k < DEPTH; k++) begin
      int t;
      t = (1 + k) % DEPTH;
      sample();
      if (k == 0) chk("bcast_calc", robs_calculated, 8'hFF);
      chk($sformatf("burst%0d_cv", k), commit_valid, 1);
      chk($sformatf("burst%0d_ctag", k), commit_tag, t);
      chk($sformatf("burst%0d_crd", k), commit_rd, (t == 0) ? 30 : 10 + t);
      chk($sformatf("burst%0d_cdata", k), commit_data, 100 + t);
      tick();
    end
    sample();
    chk_idle_state("burst_done", 3'd1);
    tick();

`ifdef ROB_FLUSH_EN
    // Flush with four entries, two of them ready at the head
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      rob_load = 1'b1;
      alloc_rd = REG_W'(1 + i);
      tick();
    end
    idle_inputs();
    set_cdb(8'h03, 32'd42, 1'b0);
    tick();
    idle_inputs();
    flush    = 1'b1;
    rob_load = 1'b1;
    alloc_rd = 5'd5;
    set_cdb(8'h04, 32'd9, 1'b0);
    sample();
    chk("flush_cv", commit_valid, 0);
    chk("flush_calc_pre", robs_calculated, 8'h03);
    tick();
    idle_inputs();
    sample();
    chk_idle_state("flush_after", 3'd0);
    chk("flush_data_kept", rd_data_a, 32'd42);
    tick();
`else
    $display("note: built without ROB_FLUSH_EN, flush port not present");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
